// File: rtl/player_auth_pkg.sv
// Shared types and defaults for the player login controller.
package player_auth_pkg;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    SCAN    = 2'd1,
    GRANTED = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam int ROM_LATENCY     = 1;
  localparam int DEF_DIGITS      = 4;
  localparam int DEF_DIGIT_W     = 4;
  localparam int DEF_NUM_PLAYERS = 8;
  localparam int DEF_ADDR_W      = 5;
  localparam int DEF_PID_W       = 3;

endpackage

// File: rtl/code_entry_buf.sv
// Keypad digit buffer: shifts digits in MSB-first, supports backspace and clear.
module code_entry_buf
  import player_auth_pkg::*;
#(
  parameter int DIGITS  = DEF_DIGITS,
  parameter int DIGIT_W = DEF_DIGIT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_i,
  input  logic                        back_i,
  input  logic                        clear_i,
  input  logic [DIGIT_W-1:0]          digit_i,
  output logic [DIGITS*DIGIT_W-1:0]   code_o,
  output logic                        full_o
);

  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(DIGITS + 1);

  logic [CODE_W-1:0] code_q, code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // One slot left: the next load completes the code.
  assign full_o = (cnt_q == CNT_W'(DIGITS - 1));
  assign code_o = code_q;

  always_comb begin
    code_d = code_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      code_d = '0;
      cnt_d  = '0;
    end else if (load_i) begin
      code_d = {code_q[CODE_W-DIGIT_W-1:0], digit_i};
      cnt_d  = full_o ? '0 : cnt_q + 1'b1;
    end else if (back_i && (cnt_q != '0)) begin
      code_d = code_q >> DIGIT_W;
      cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q <= '0;
      cnt_q  <= '0;
    end else begin
      code_q <= code_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/player_auth_ctrl.sv
// Player login controller: collects a code, scans the player-ID ROM, reports status.
// Optional brute-force lockout is built when PLAYER_AUTH_LOCKOUT_EN is defined.
module player_auth_ctrl
  import player_auth_pkg::*;
#(
  parameter int DIGITS      = DEF_DIGITS,
  parameter int DIGIT_W     = DEF_DIGIT_W,
  parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int PID_W       = DEF_PID_W,
  parameter int GUEST_PID   = 0,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIGIT_W-1:0]        user_digit,
  input  logic                      user_load,
  input  logic                      user_back,
  input  logic                      logout,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DIGITS*DIGIT_W-1:0] rom_data,
  output logic                      matched_id,
  output logic [PID_W-1:0]          player_id,
  output logic                      is_guest,
  output logic                      busy,
  output logic                      auth_fail,
  output logic                      locked
);

  localparam int                CODE_W     = DIGITS * DIGIT_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_PLAYERS - 1);
  localparam logic [ADDR_W-1:0] GUEST_ADDR = ADDR_W'(GUEST_PID);

  if ((NUM_PLAYERS > 2**ADDR_W) || (NUM_PLAYERS > 2**PID_W) || (MAX_FAILS < 1) ||
      (LOCK_CYCLES < 1) || (ROM_LATENCY != 1)) begin : g_bad_cfg
    $error("player_auth_ctrl: unsupported parameter set");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              data_vld_q;
  logic [ADDR_W-1:0] data_idx_q;
  logic              matched_q, matched_d;
  logic [PID_W-1:0]  pid_q, pid_d;
  logic              guest_q, guest_d;
  logic              fail_q, fail_d;
  logic [CODE_W-1:0] code;
  logic              full, buf_load, buf_back, buf_clear, hit, last_cmp;

`ifdef PLAYER_AUTH_LOCKOUT_EN
  localparam int FC_W = $clog2(MAX_FAILS + 1);
  localparam int LC_W = $clog2(LOCK_CYCLES + 1);
  logic [FC_W-1:0] fails_q, fails_d;
  logic [LC_W-1:0] lock_q, lock_d;
`endif

  assign buf_load  = (state_q == ENTRY) && user_load;
  assign buf_back  = (state_q == ENTRY) && user_back;
  assign buf_clear = (state_d == ENTRY) && (state_q != ENTRY);

  code_entry_buf #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .back_i  (buf_back),
    .clear_i (buf_clear),
    .digit_i (user_digit),
    .code_o  (code),
    .full_o  (full)
  );

  // rom_data this cycle belongs to the address issued last cycle (data_idx_q).
  assign hit      = (state_q == SCAN) && data_vld_q && (rom_data == code);
  assign last_cmp = (state_q == SCAN) && data_vld_q && (data_idx_q == LAST_ADDR);

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    matched_d  = matched_q;
    pid_d      = pid_q;
    guest_d    = guest_q;
    fail_d     = 1'b0;
`ifdef PLAYER_AUTH_LOCKOUT_EN
    fails_d    = fails_q;
    lock_d     = lock_q;
`endif
    unique case (state_q)
      ENTRY: begin
        if (buf_load && full) begin
          state_d    = SCAN;
          rom_addr_d = '0;
        end
      end
      SCAN: begin
        if (rom_addr_q != LAST_ADDR) rom_addr_d = rom_addr_q + 1'b1;
        if (hit) begin
          state_d   = GRANTED;
          matched_d = 1'b1;
          pid_d     = PID_W'(data_idx_q);
          guest_d   = (data_idx_q == GUEST_ADDR);
`ifdef PLAYER_AUTH_LOCKOUT_EN
          fails_d   = '0;
`endif
        end else if (last_cmp) begin
          fail_d  = 1'b1;
          state_d = ENTRY;
`ifdef PLAYER_AUTH_LOCKOUT_EN
          if (fails_q != FC_W'(MAX_FAILS)) fails_d = fails_q + 1'b1;
          if (int'(fails_q) + 1 >= MAX_FAILS) begin
            state_d = LOCKED;
            lock_d  = LC_W'(LOCK_CYCLES - 1);
          end
`endif
        end
      end
      GRANTED: begin
        if (logout) begin
          state_d   = ENTRY;
          matched_d = 1'b0;
          pid_d     = '0;
          guest_d   = 1'b0;
        end
      end
      LOCKED: begin
`ifdef PLAYER_AUTH_LOCKOUT_EN
        if (lock_q == '0) begin
          state_d = ENTRY;
          fails_d = '0;
        end else begin
          lock_d = lock_q - 1'b1;
        end
`else
        state_d = ENTRY;
`endif
      end
      default: state_d = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ENTRY;
      rom_addr_q <= '0;
      data_vld_q <= 1'b0;
      matched_q  <= 1'b0;
      pid_q      <= '0;
      guest_q    <= 1'b0;
      fail_q     <= 1'b0;
`ifdef PLAYER_AUTH_LOCKOUT_EN
      fails_q    <= '0;
      lock_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      data_vld_q <= (state_q == SCAN);
      matched_q  <= matched_d;
      pid_q      <= pid_d;
      guest_q    <= guest_d;
      fail_q     <= fail_d;
`ifdef PLAYER_AUTH_LOCKOUT_EN
      fails_q    <= fails_d;
      lock_q     <= lock_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    data_idx_q <= rom_addr_q;
  end

  assign rom_addr   = rom_addr_q;
  assign matched_id = matched_q;
  assign player_id  = pid_q;
  assign is_guest   = guest_q;
  assign busy       = (state_q == SCAN);
  assign auth_fail  = fail_q;
`ifdef PLAYER_AUTH_LOCKOUT_EN
  assign locked     = (state_q == LOCKED);
`else
  assign locked     = 1'b0;
`endif

endmodule

// File: tb/tb_player_auth_ctrl.sv
// Directed bench for player_auth_ctrl with a registered 1-cycle ROM model.
module tb_player_auth_ctrl;

  localparam int LOCK_CYC = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  user_digit;
  logic        user_load, user_back, logout;
  logic [4:0]  rom_addr;
  logic [15:0] rom_data;
  logic        matched_id, is_guest, busy, auth_fail, locked;
  logic [2:0]  player_id;

  logic [15:0] rom [0:31];
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] code;
    logic        mt;
    logic [2:0]  pid;
    logic        gst;
    int          lat;
  } vec_t;
  vec_t vecs [5];

  player_auth_ctrl #(.DIGITS(4), .DIGIT_W(4), .NUM_PLAYERS(8), .ADDR_W(5), .PID_W(3),
                     .GUEST_PID(0), .MAX_FAILS(3), .LOCK_CYCLES(LOCK_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .user_digit (user_digit),
    .user_load  (user_load),
    .user_back  (user_back),
    .logout     (logout),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .matched_id (matched_id),
    .player_id  (player_id),
    .is_guest   (is_guest),
    .busy       (busy),
    .auth_fail  (auth_fail),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  initial begin
    #100000;
    $display("FAIL watchdog: actual still running, required finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_digit(input logic [3:0] d, input logic with_back);
    user_digit = d;
    user_load  = 1'b1;
    user_back  = with_back;
    tick();
    user_load  = 1'b0;
    user_back  = 1'b0;
  endtask

  task automatic load_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) load_digit(c[i*4 +: 4], 1'b0);
  endtask

  task automatic logout_chk(input string nm);
    logout = 1'b1;
    tick();
    logout = 1'b0;
    chk({nm, "_lo_match"}, 32'(matched_id), 32'd0);
    chk({nm, "_lo_pid"},   32'(player_id),  32'd0);
    chk({nm, "_lo_guest"}, 32'(is_guest),   32'd0);
  endtask

  // Entry k is compared k+2 edges after the completing load; busy spans those cycles.
  task automatic await_result(input string nm, input logic mt, input logic [2:0] pid,
                              input logic gst, input int lat, input logic do_logout);
    int n;
    int bcnt;
    n = 0;
    bcnt = 0;
    while (n < 20 && !matched_id && !auth_fail) begin
      if (busy) bcnt++;
      tick();
      n++;
    end
    chk({nm, "_lat"},     n,    lat);
    chk({nm, "_busycyc"}, bcnt, lat);
    chk({nm, "_busyoff"}, 32'(busy),       32'd0);
    chk({nm, "_match"},   32'(matched_id), 32'(mt));
    chk({nm, "_pid"},     32'(player_id),  mt ? 32'(pid) : 32'd0);
    chk({nm, "_guest"},   32'(is_guest),   mt ? 32'(gst) : 32'd0);
    chk({nm, "_fail"},    32'(auth_fail),  32'(!mt));
    if (!mt) begin
      tick();
      chk({nm, "_failpulse"}, 32'(auth_fail), 32'd0);
    end else if (do_logout) begin
      logout_chk(nm);
    end
  endtask

  initial begin
    int k;
    rst = 1'b1;
    user_digit = '0;
    user_load = 1'b0;
    user_back = 1'b0;
    logout = 1'b0;
    for (int a = 0; a < 32; a++) rom[a] = 16'h9999;
    rom[0] = 16'h0000;
    rom[1] = 16'h4321;
    rom[2] = 16'h1734;
    rom[3] = 16'h5555;
    rom[4] = 16'h2222;
    rom[5] = 16'h1234;
    rom[6] = 16'h1234;
    rom[7] = 16'h8888;

    vecs[0] = '{code: 16'h1234, mt: 1'b1, pid: 3'd5, gst: 1'b0, lat: 7};
    vecs[1] = '{code: 16'h0000, mt: 1'b1, pid: 3'd0, gst: 1'b1, lat: 2};
    vecs[2] = '{code: 16'h9999, mt: 1'b0, pid: 3'd0, gst: 1'b0, lat: 9};
    vecs[3] = '{code: 16'h8888, mt: 1'b1, pid: 3'd7, gst: 1'b0, lat: 9};
    vecs[4] = '{code: 16'h4321, mt: 1'b1, pid: 3'd1, gst: 1'b0, lat: 3};

    tick();
    tick();
    rst = 1'b0;
    chk("rst_match", 32'(matched_id), 32'd0);
    chk("rst_pid",   32'(player_id),  32'd0);
    chk("rst_guest", 32'(is_guest),   32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_fail",  32'(auth_fail),  32'd0);
    chk("rst_lock",  32'(locked),     32'd0);
    chk("rst_addr",  32'(rom_addr),   32'd0);

    for (int i = 0; i < 5; i++) begin
      load_code(vecs[i].code);
      await_result($sformatf("vec%0d", i), vecs[i].mt, vecs[i].pid, vecs[i].gst,
                   vecs[i].lat, 1'b1);
      tick();
    end

    // Backspace on an empty buffer, then 1,2,back,7(+back),3,4 -> 1734 at entry 2.
    user_back = 1'b1;
    tick();
    user_back = 1'b0;
    load_digit(4'h1, 1'b0);
    load_digit(4'h2, 1'b0);
    user_back = 1'b1;
    tick();
    user_back = 1'b0;
    load_digit(4'h7, 1'b1);
    load_digit(4'h3, 1'b0);
    load_digit(4'h4, 1'b0);
    await_result("bksp", 1'b1, 3'd2, 1'b0, 4, 1'b0);

    for (int i = 0; i < 4; i++) begin
      user_digit = 4'h5;
      user_load = 1'b1;
      user_back = (i % 2) == 1;
      tick();
    end
    user_load = 1'b0;
    user_back = 1'b0;
    tick();
    chk("hold_match", 32'(matched_id), 32'd1);
    chk("hold_pid",   32'(player_id),  32'd2);
    chk("hold_busy",  32'(busy),       32'd0);
    logout_chk("hold");
    tick();

    // Reset in the middle of a scan.
    load_code(16'h9999);
    k = 0;
    while (rom_addr != 5'd3 && k < 10) begin
      tick();
      k++;
    end
    chk("mid_addr3", 32'(rom_addr), 32'd3);
    chk("mid_busy",  32'(busy),     32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy",  32'(busy),       32'd0);
    chk("mid_rst_match", 32'(matched_id), 32'd0);
    chk("mid_rst_pid",   32'(player_id),  32'd0);
    chk("mid_rst_fail",  32'(auth_fail),  32'd0);
    chk("mid_rst_addr",  32'(rom_addr),   32'd0);
    load_code(16'h1234);
    await_result("after_rst", 1'b1, 3'd5, 1'b0, 7, 1'b1);
    tick();

    // Three consecutive bad codes.
    for (int i = 0; i < 3; i++) begin
      load_code(16'h9999);
      await_result($sformatf("bad%0d", i), 1'b0, 3'd0, 1'b0, 9, 1'b0);
    end
`ifdef PLAYER_AUTH_LOCKOUT_EN
    chk("lock_on", 32'(locked), 32'd1);
    k = 0;
    while (locked && k < 50) begin
      user_digit = 4'h1;
      user_load = 1'b1;
      tick();
      k++;
    end
    user_load = 1'b0;
    chk("lock_len", k + 1, LOCK_CYC);
`else
    chk("nolock", 32'(locked), 32'd0);
`endif
    chk("post_bad_lock", 32'(locked), 32'd0);
    load_code(16'h1234);
    await_result("post_bad", 1'b1, 3'd5, 1'b0, 7, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
